// File: rtl/switch_debouncer_channel.sv
// One debounced input: two-flop synchronizer, tick-gated stability counter,
// registered level and single-clock rise/fall pulses.
module debounce_channel #(
  parameter int STABLE_TICKS = 8,
  parameter int COUNT_BITS   = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [COUNT_BITS-1:0] TERM_CNT = COUNT_BITS'(STABLE_TICKS - 1);

  logic                  meta_q;
  logic                  sync_q;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any return of sync to level discards the pending count, tick or not.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == TERM_CNT) begin
        level_d = sync_q;
        cnt_d   = '0;
        rise_d  = sync_q;
        fall_d  = ~sync_q;
      end else begin
        cnt_d = cnt_q + COUNT_BITS'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer; one independent debounce_channel per raw
// input, all sampled on the shared prescaler tick.
module switch_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_TICKS = 8,
  parameter int COUNT_BITS   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  if (STABLE_TICKS < 1 || (2 ** COUNT_BITS) < STABLE_TICKS) begin : g_param_check
    $error("switch_debouncer: STABLE_TICKS must be >= 1 and fit in COUNT_BITS");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .COUNT_BITS  (COUNT_BITS)
    ) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .tick_i (tick),
      .raw_i  (raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent raw inputs.
REQ-002 SHALL have parameter STABLE_TICKS, default 8: consecutive ticks an input must hold a new value before it is accepted; legal range ≥1.
REQ-003 SHALL have parameter COUNT_BITS, default 4: stability counter width; must satisfy 2^COUNT_BITS ≥ STABLE_TICKS.
REQ-004 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick  input  1  single-clock sample strobe from the upstream prescaler; any duty is legal, including tied high.
REQ-007 SHALL have port raw  input  CHANNELS  asynchronous switch/button levels.
REQ-008 SHALL have port level  output  CHANNELS  debounced level, registered.
REQ-009 SHALL have port rise  output  CHANNELS  one-clock pulse on each accepted 0→1 change of level, registered.
REQ-010 SHALL have port fall  output  CHANNELS  one-clock pulse on each accepted 1→0 change of level, registered.

Function
REQ-011 SHALL pass each raw bit through a two-flop synchronizer; the second-stage output is called sync.
REQ-012 SHALL keep, per channel, a COUNT_BITS stability counter, advanced only on clocks where tick=1.
REQ-013 SHALL clear a channel's counter on any clock where sync equals level, regardless of tick.
REQ-014 SHALL increment the counter on a clock where sync differs from level, tick=1, and counter < STABLE_TICKS-1.
REQ-015 SHALL, on a clock where sync differs from level, tick=1, and counter = STABLE_TICKS-1, load level with sync, clear the counter, and assert rise or fall for that channel on the same edge.
REQ-016 SHALL hold the counter unchanged on a clock where sync differs from level and tick=0.
REQ-017 SHALL drive rise and fall high for exactly one clock per accepted change; never both high on the same channel.
REQ-018 SHALL discard any excursion of sync that returns to level before acceptance: no level change, no pulse, counter reset to 0.
REQ-019 SHALL, with tick tied high, change level exactly 2+STABLE_TICKS rising edges after a stable raw change is first sampled.
REQ-020 SHALL process channels independently; simultaneous changes on several channels in opposite directions SHALL each produce their own pulse on the same edge.
REQ-021 SHALL never wrap a counter; it saturates at STABLE_TICKS-1 by construction of REQ-014/015.
REQ-022 SHALL, with STABLE_TICKS=1, accept a difference on the first tick after it appears in sync.

Reset
REQ-023 SHALL, while reset_n=0, clear both synchronizer stages, all counters, level, rise and fall to 0 asynchronously.
REQ-024 SHALL, after reset_n deasserts, treat a raw input already held at 1 as a new change and debounce it in full (rise pulse after 2+STABLE_TICKS ticked clocks).
REQ-025 SHALL abandon any in-progress count when reset is asserted mid-operation; no pulse is emitted for it.

Structure
REQ-026 SHALL place no typedefs in a shared package; only the parameters above are used.
REQ-027 SHALL instantiate one sub-module, debounce_channel, per channel (synchronizer, counter, level, rise, fall for one bit) via a generate loop.
REQ-028 SHALL be driven by the existing tick prescaler; no internal prescaling.

Verification (CHANNELS=4, STABLE_TICKS=8 unless stated)
REQ-029 SHALL test tick=1, raw[0] 0→1 held -> level[0]=1 and rise[0]=1 on edge 10 after the change, rise[0]=0 on edge 11, fall all 0, other channels unchanged.
REQ-030 SHALL test tick=1, raw[1] high for 5 clocks then low -> level[1] stays 0, no rise/fall, counter back to 0.
REQ-031 SHALL test tick from the prescaler with SCALE=4, raw[2] held 1 -> level[2] rises on the 8th tick after sync goes high, i.e. 29–32 clocks after sync changes depending on tick phase, with exactly one rise pulse.
REQ-032 SHALL test level=0101, raw 0101→1010 in one clock, tick=1 -> on one edge level=1010, rise=1010, fall=0101.
REQ-033 SHALL test raw[3] held 1 and reset_n pulsed low at count 5 -> outputs 0 during reset, no pulse, then rise[3] exactly 10 edges after reset release.
REQ-034 SHALL test tick held 0 for 100 clocks with raw=1111 -> level stays 0000, no pulses; on enabling tick=1, level=1111 after 8 ticks.
